// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the sequence generator.
package fsm_seq_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } ctrl_e;

   // Values of the mode input / latched mode register
   localparam logic MODE_LOOP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/fsm_dwell_cnt.sv
// Dwell counter: counts 0..limit_i while enabled, wraps to 0 at terminal count.
// Clear has priority over enable; tc_o flags the last cycle of a state.
module fsm_dwell_cnt
   import fsm_seq_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [DWELL_W-1:0] limit_i,
   output logic               tc_o
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   assign tc_o = (cnt_q == limit_i);

   // Next count: clear, wrap at terminal count, or increment when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {DWELL_W{1'b0}};
      end else if (en_i) begin
         if (tc_o) begin
            cnt_d = {DWELL_W{1'b0}};
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {DWELL_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fsm_seq_gen.sv
// Programmable sequence generator: steps through N_STATES states, each held for
// a latched dwell count, driving one pattern bit per state. Loop or one-shot,
// with start/stop/pause control and registered busy/done/wrap status.
module fsm_seq_gen
   import fsm_seq_pkg::*;
#(
   parameter int  N_STATES = 4,
   parameter int  DWELL_W  = 8,
   localparam int IDX_W    = $clog2(N_STATES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                pause,
   input  logic                mode,
   input  logic [DWELL_W-1:0]  dwell_cfg,
   input  logic [N_STATES-1:0] pattern_cfg,
   output logic                state_out,
   output logic [IDX_W-1:0]    state_idx,
   output logic                busy,
   output logic                done,
   output logic                wrap
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATES - 1);

   ctrl_e               ctrl_q, ctrl_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                mode_q, mode_d;
   // Stored as max(dwell_cfg,1)-1 so the counter compares against it directly
   logic [DWELL_W-1:0]  limit_q, limit_d;
   logic [N_STATES-1:0] pattern_q, pattern_d;
   logic                state_out_q, state_out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wrap_q, wrap_d;
   logic                cnt_clr_s;
   logic                cnt_en_s;
   logic                cnt_tc_s;

   fsm_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr_s),
      .en_i    (cnt_en_s),
      .limit_i (limit_q),
      .tc_o    (cnt_tc_s)
   );

   // Control FSM next state, config latching, index advance and output values
   always_comb begin
      ctrl_d    = ctrl_q;
      idx_d     = idx_q;
      mode_d    = mode_q;
      limit_d   = limit_q;
      pattern_d = pattern_q;
      done_d    = 1'b0;
      wrap_d    = 1'b0;
      cnt_clr_s = 1'b0;
      cnt_en_s  = 1'b0;
      case (ctrl_q)
         IDLE: begin
            cnt_clr_s = 1'b1;
            idx_d     = {IDX_W{1'b0}};
            if (start && !stop) begin
               ctrl_d    = RUN;
               mode_d    = mode;
               limit_d   = (dwell_cfg == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                          : dwell_cfg - DWELL_W'(1);
               pattern_d = pattern_cfg;
            end else begin
               ctrl_d = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               ctrl_d    = IDLE;
               idx_d     = {IDX_W{1'b0}};
               cnt_clr_s = 1'b1;
            end else if (pause) begin
               // Freeze: counter and index keep the values sampled this edge
               ctrl_d = PAUSE;
            end else begin
               cnt_en_s = 1'b1;
               if (cnt_tc_s) begin
                  if (idx_q == LAST_IDX) begin
                     idx_d = {IDX_W{1'b0}};
                     if (mode_q == MODE_ONESHOT) begin
                        ctrl_d = IDLE;
                        done_d = 1'b1;
                     end else begin
                        wrap_d = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  idx_d = idx_q;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               ctrl_d    = IDLE;
               idx_d     = {IDX_W{1'b0}};
               cnt_clr_s = 1'b1;
            end else if (pause) begin
               ctrl_d = PAUSE;
            end else begin
               // Resume from the frozen count; this edge does not count
               ctrl_d = RUN;
            end
         end
         default: begin
            ctrl_d    = IDLE;
            idx_d     = {IDX_W{1'b0}};
            cnt_clr_s = 1'b1;
         end
      endcase
      busy_d      = (ctrl_d != IDLE);
      state_out_d = busy_d ? pattern_d[idx_d] : 1'b0;
   end

   // State, config and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q      <= IDLE;
         idx_q       <= {IDX_W{1'b0}};
         mode_q      <= MODE_LOOP;
         limit_q     <= {DWELL_W{1'b0}};
         pattern_q   <= {N_STATES{1'b0}};
         state_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         limit_q     <= limit_d;
         pattern_q   <= pattern_d;
         state_out_q <= state_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
      end
   end

   assign state_out = state_out_q;
   assign state_idx = idx_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen (N_STATES=4, DWELL_W=8, 20 ns clock).
module tb_fsm_seq_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       pause = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] dwell_cfg = 8'd0;
   logic [3:0] pattern_cfg = 4'd0;
   logic       state_out;
   logic [1:0] state_idx;
   logic       busy;
   logic       done;
   logic       wrap;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       start, stop, pause, mode;
      logic [7:0] dwell;
      logic [3:0] pat;
      logic       e_out;
      logic [1:0] e_idx;
      logic       e_busy, e_done, e_wrap;
   } vec_t;

   vec_t vecs[$];

   always #10 clk = ~clk;

   fsm_seq_gen #(.N_STATES(4), .DWELL_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .mode        (mode),
      .dwell_cfg   (dwell_cfg),
      .pattern_cfg (pattern_cfg),
      .state_out   (state_out),
      .state_idx   (state_idx),
      .busy        (busy),
      .done        (done),
      .wrap        (wrap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic eo, input logic [1:0] ei,
                          input logic eb, input logic ed, input logic ew);
      chk({tag, " state_out"}, 32'(state_out), 32'(eo));
      chk({tag, " state_idx"}, 32'(state_idx), 32'(ei));
      chk({tag, " busy"},      32'(busy),      32'(eb));
      chk({tag, " done"},      32'(done),      32'(ed));
      chk({tag, " wrap"},      32'(wrap),      32'(ew));
   endtask

   function automatic void add(input logic st, input logic sp, input logic pa, input logic md,
                               input logic [7:0] dw, input logic [3:0] pt,
                               input logic eo, input logic [1:0] ei,
                               input logic eb, input logic ed, input logic ew);
      vec_t v;
      v.start = st; v.stop = sp; v.pause = pa; v.mode = md;
      v.dwell = dw; v.pat = pt;
      v.e_out = eo; v.e_idx = ei; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
      vecs.push_back(v);
   endfunction

   // Each row: drive inputs for one cycle, clock, then compare the registered outputs
   task automatic run_table(input string tname);
      for (int i = 0; i < vecs.size(); i++) begin
         start       = vecs[i].start;
         stop        = vecs[i].stop;
         pause       = vecs[i].pause;
         mode        = vecs[i].mode;
         dwell_cfg   = vecs[i].dwell;
         pattern_cfg = vecs[i].pat;
         tick();
         chk_all($sformatf("%s row%0d", tname, i), vecs[i].e_out, vecs[i].e_idx,
                 vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wrap);
      end
      vecs.delete();
      start = 1'b0; stop = 1'b0; pause = 1'b0;
   endtask

   initial begin
      logic [3:0] pat;
      int         exp_idx;
      int         n1;
      int         done_seen;

      // ---- 1: reset held two cycles, then release
      tick();
      tick();
      chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      #5 reset = 1'b0;
      tick();
      tick();
      chk_all("post_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

      // ---- 2: loop, dwell 3, pattern 1010; config and start changed mid-run (ignored)
      add(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 4'b1010, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); // c1
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); // c2
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); // c3
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0); // c4
      add(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0); // c5
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0); // c6
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); // c7
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); // c8
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0); // c9
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0); // c10
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0); // c11
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0); // c12
      add(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 4'b0101, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1); // c13
      run_table("loop");
      // Second lap from a small model: 3 cycles per state, wrap on every 12th cycle
      pat = 4'b1010;
      for (int c = 14; c <= 25; c++) begin
         tick();
         exp_idx = ((c - 1) / 3) % 4;
         chk_all($sformatf("loop c%0d", c), pat[exp_idx], 2'(exp_idx), 1'b1, 1'b0,
                 ((c - 1) % 12) == 0);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("loop stop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

      // ---- 3: one-shot, dwell 2, pattern 0110; then start+stop together; then 6: dwell 0
      add(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 4'b0110, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); // c1
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0); // c2
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0); // c3
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0); // c4
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); // c5
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0); // c6
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0); // c7
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0); // c8
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0); // c9 done
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 4'b1001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); // c10
      add(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0); // start+stop
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'b1001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0); // dwell 0
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      run_table("oneshot");

      // ---- 4: loop, dwell 4, pattern 0010; pause for 5 cycles during state 1.
      // State 1 is entered at c5; one counted cycle, pause c6..c10 (the c6 edge is
      // frozen), resume edge at c11, three more counted cycles: idx==1 for c5..c14.
      mode = 1'b0; dwell_cfg = 8'd4; pattern_cfg = 4'b0010; start = 1'b1;
      tick();
      start = 1'b0;
      n1 = 0;
      for (int c = 1; c <= 20; c++) begin
         if (state_idx == 2'd1) n1++;
         if (c >= 7 && c <= 11) begin
            chk($sformatf("pause hold idx c%0d", c), 32'(state_idx), 32'd1);
            chk($sformatf("pause hold out c%0d", c), 32'(state_out), 32'd1);
         end
         pause = (c >= 6 && c <= 10);
         tick();
      end
      chk("pause state1 length", 32'(n1), 32'd10);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("pause stop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

      // ---- 5: one-shot, dwell 3, pattern 0100; stop while in state 2
      mode = 1'b1; dwell_cfg = 8'd3; pattern_cfg = 4'b0100; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 2; c <= 7; c++) tick();
      chk("stop pre idx", 32'(state_idx), 32'd2);
      chk("stop pre out", 32'(state_out), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("stop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) done_seen++;
      end
      chk("stop no done", 32'(done_seen), 32'd0);

      // ---- 6: reset mid-run, then a clean loop run (dwell 1, pattern 0101)
      mode = 1'b1; dwell_cfg = 8'd5; pattern_cfg = 4'b1111; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("prereset busy", 32'(busy), 32'd1);
      #5 reset = 1'b1;
      #1;
      chk_all("midrun reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      #5 reset = 1'b0;
      tick();
      chk_all("reset release", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      mode = 1'b0; dwell_cfg = 8'd1; pattern_cfg = 4'b0101; start = 1'b1;
      tick();
      start = 1'b0;
      chk_all("rerun c1", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("rerun c2", 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("rerun c3", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("rerun c4", 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("rerun c5", 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk_all("rerun stop", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
